robot_fsm: RTL and testbench
============================

// Module: robot_fsm
// PURPOSE
//   Top-level mission controller for the delivery robot. Consumes bell, vision
//   (pixel_location, color_mode), range (distance, proximity) and host command
//   (hex_data) inputs. Drives a 5-bit motor command and a display-override flag.
//   Sits between the sensor front-ends and the motor driver / HEX display mux.
// PARAMETERS
//   STOP_DIST       8'd20         distance at or below this value forces STOP (same as proximity=1)
//   SEARCH_TIMEOUT  32'd50_000_000  cycles in SEARCH with no target before ABORT
//   RETURN_CYCLES   32'd8         cycles spent in RESET2 before re-entering SEARCH
//   ABORT_WORD      32'hDEAD_0000 hex_data value that forces ABORT from any non-IDLE state
// PORTS
//   CLOCK_50        in   1   system clock, 50 MHz; all state on rising edge
//   KEY             in   2   KEY[0]: asynchronous active-low reset; KEY[1]: active-low user button
//   bell            in   1   start/restart request, synchronous, level
//   hex_data        in   32  host command word (only ABORT_WORD is decoded)
//   distance        in   8   range to object, unsigned
//   proximity       in   1   1 = object close
//   pixel_location  in   3   target position: 100 left, 010 centre, 001 right, else none
//   color_mode      in   2   target colour select
//   overwrite       out  1   1 = FSM overrides the HEX display content
//   motor_state     out  5   motor command (codes below)
// BEHAVIOUR
//   Reset: one clock (CLOCK_50); KEY[0]=0 asynchronously forces state IDLE, motor_state 5'b00000,
//     overwrite 0, all counters 0, and the KEY[1] synchroniser to 1 (released).
//   KEY[1] passes a 2-flop synchroniser; "press" = synchronised value 0. bell, proximity,
//     pixel_location, distance, hex_data are synchronous and used directly.
//   "close" = proximity | (distance <= STOP_DIST).
//   Motor codes: STOP 00000, FWD 00001, LEFT 00010, RIGHT 00100, SPIN 01000, REV 10000.
//   Outputs are registered Moore outputs of the next state; they are valid 1 cycle after the transition.
//   States/outputs: IDLE STOP/0, SEARCH SPIN/0, FORWARD FWD/0, TURN_L LEFT/0, TURN_R RIGHT/0,
//     HALT STOP/0, ARRIVED STOP/1, RESET1 STOP/1, RESET2 REV/1, ABORT STOP/1.
//   Global: hex_data==ABORT_WORD in any state except IDLE -> ABORT. This has highest priority.
//   IDLE: bell -> SEARCH.
//   SEARCH: 010->FORWARD, 100->TURN_L, 001->RIGHT (TURN_R). Any other code stays in SEARCH and the
//     timeout counter increments. When the counter reaches SEARCH_TIMEOUT-1 -> ABORT. The counter
//     clears on entry to SEARCH.
//   FORWARD/TURN_L/TURN_R, priority order:
//     1. close -> HALT.
//     2. color_mode differs from its value latched on SEARCH exit -> SEARCH.
//     3. Otherwise steer by pixel: 010 FORWARD, 100 TURN_L, 001 TURN_R, any other code -> SEARCH.
//   HALT: close -> stay. Not close and pixel 010 -> ARRIVED. Not close and any other pixel -> SEARCH.
//   ARRIVED: KEY[1] press -> RESET1. Otherwise stay.
//   RESET1: KEY[1] released -> RESET2. Otherwise stay.
//   RESET2: bell -> SEARCH immediately. Otherwise after RETURN_CYCLES cycles -> SEARCH.
//     The counter clears on entry.
//   ABORT: bell -> SEARCH; KEY[1] press (without bell) -> IDLE. bell wins if both are present.
//   Undefined pixel codes (011, 101, 110, 111) are treated as "none".
//   Reset asserted mid-mission returns to IDLE immediately; nothing is retained.
// STRUCTURE
//   Package robot_fsm_pkg: state_t enum (10 states, 4-bit encoding) and the MOTOR_* localparams.
//   Sub-module btn_sync: 2-flop active-low synchroniser for KEY[1], reset to 1.
//   The rest is a single always_ff state/counter process plus an always_comb next-state process.
// TESTING
//   Reset: KEY[0]=0 for 1 cycle -> motor_state=00000, overwrite=0, IDLE; bell held 0 -> stays IDLE.
//   bell pulse -> SPIN 01000. Then pixel 010 -> 00001, pixel 001 -> 00100, pixel 100 -> 00010,
//     pixel 000 -> 01000.
//   In FORWARD, proximity=1 -> 00000. proximity=0 with pixel 010 -> ARRIVED (overwrite=1).
//     Separately, distance=STOP_DIST with proximity=0 also stops.
//   ARRIVED, KEY[1]=0 for 3 cycles then 1 -> RESET1 then RESET2 (motor 10000, overwrite=1).
//     After RETURN_CYCLES -> SEARCH (01000, overwrite 0).
//   SEARCH with pixel 000 and SEARCH_TIMEOUT=10 -> ABORT after 10 cycles (00000, overwrite 1).
//     bell -> SEARCH.
//   hex_data=ABORT_WORD during FORWARD -> ABORT on the next cycle. Then KEY[1] press -> IDLE.

Source files
------------

// File: rtl/robot_fsm_pkg.sv
// rtl/robot_fsm_pkg.sv - state encoding, motor codes and decode helpers for robot_fsm
package robot_fsm_pkg;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_SEARCH  = 4'd1;
  localparam logic [3:0] ST_FORWARD = 4'd2;
  localparam logic [3:0] ST_TURN_L  = 4'd3;
  localparam logic [3:0] ST_TURN_R  = 4'd4;
  localparam logic [3:0] ST_HALT    = 4'd5;
  localparam logic [3:0] ST_ARRIVED = 4'd6;
  localparam logic [3:0] ST_RESET1  = 4'd7;
  localparam logic [3:0] ST_RESET2  = 4'd8;
  localparam logic [3:0] ST_ABORT   = 4'd9;

  typedef enum logic [3:0] {
    IDLE    = ST_IDLE,
    SEARCH  = ST_SEARCH,
    FORWARD = ST_FORWARD,
    TURN_L  = ST_TURN_L,
    TURN_R  = ST_TURN_R,
    HALT    = ST_HALT,
    ARRIVED = ST_ARRIVED,
    RESET1  = ST_RESET1,
    RESET2  = ST_RESET2,
    ABORT   = ST_ABORT
  } state_t;

  localparam logic [4:0] MOTOR_STOP  = 5'b00000;
  localparam logic [4:0] MOTOR_FWD   = 5'b00001;
  localparam logic [4:0] MOTOR_LEFT  = 5'b00010;
  localparam logic [4:0] MOTOR_RIGHT = 5'b00100;
  localparam logic [4:0] MOTOR_SPIN  = 5'b01000;
  localparam logic [4:0] MOTOR_REV   = 5'b10000;

  localparam logic [2:0] PIX_LEFT   = 3'b100;
  localparam logic [2:0] PIX_CENTER = 3'b010;
  localparam logic [2:0] PIX_RIGHT  = 3'b001;

  // Undefined pixel codes fall through to SEARCH, i.e. "no target".
  function automatic state_t steer(input logic [2:0] pixel);
    case (pixel)
      PIX_CENTER: return FORWARD;
      PIX_LEFT:   return TURN_L;
      PIX_RIGHT:  return TURN_R;
      default:    return SEARCH;
    endcase
  endfunction

  function automatic logic [4:0] motor_of(input state_t s);
    case (s)
      SEARCH:  return MOTOR_SPIN;
      FORWARD: return MOTOR_FWD;
      TURN_L:  return MOTOR_LEFT;
      TURN_R:  return MOTOR_RIGHT;
      RESET2:  return MOTOR_REV;
      default: return MOTOR_STOP;
    endcase
  endfunction

  function automatic logic overwrite_of(input state_t s);
    return (s == ARRIVED) || (s == RESET1) || (s == RESET2) || (s == ABORT);
  endfunction

endpackage

// File: rtl/robot_fsm_btn_sync.sv
// rtl/robot_fsm_btn_sync.sv - two-flop synchroniser for an active-low button, idles released
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic synced
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b1;
      synced <= 1'b1;
    end else begin
      meta   <= raw;
      synced <= meta;
    end
  end

endmodule

// File: rtl/robot_fsm.sv
// rtl/robot_fsm.sv - delivery robot mission controller driving motor command and display override
module robot_fsm
  import robot_fsm_pkg::*;
#(
  parameter logic [7:0]  STOP_DIST      = 8'd20,
  parameter logic [31:0] SEARCH_TIMEOUT = 32'd50_000_000,
  parameter logic [31:0] RETURN_CYCLES  = 32'd8,
  parameter logic [31:0] ABORT_WORD     = 32'hDEAD_0000
) (
  input  logic        CLOCK_50,
  input  logic [1:0]  KEY,
  input  logic        bell,
  input  logic [31:0] hex_data,
  input  logic [7:0]  distance,
  input  logic        proximity,
  input  logic [2:0]  pixel_location,
  input  logic [1:0]  color_mode,
  output logic        overwrite,
  output logic [4:0]  motor_state
);

  logic        rst_n;
  logic        key1_synced;
  state_t      state;
  state_t      next_state;
  logic [31:0] search_cnt;
  logic [31:0] return_cnt;
  logic [1:0]  color_latched;
  logic        close;
  logic        press;

  assign rst_n = KEY[0];

  btn_sync u_btn_sync (
    .clk    (CLOCK_50),
    .rst_n  (rst_n),
    .raw    (KEY[1]),
    .synced (key1_synced)
  );

  always_comb begin
    close      = proximity || (distance <= STOP_DIST);
    press      = !key1_synced;
    next_state = state;
    if (state != IDLE && hex_data == ABORT_WORD) begin
      next_state = ABORT;
    end else begin
      case (state)
        IDLE:    if (bell) next_state = SEARCH;
        SEARCH: begin
          next_state = steer(pixel_location);
          if (next_state == SEARCH && search_cnt == SEARCH_TIMEOUT - 32'd1)
            next_state = ABORT;
        end
        FORWARD, TURN_L, TURN_R: begin
          if (close)                           next_state = HALT;
          else if (color_mode != color_latched) next_state = SEARCH;
          else                                 next_state = steer(pixel_location);
        end
        HALT:    if (!close) next_state = (pixel_location == PIX_CENTER) ? ARRIVED : SEARCH;
        ARRIVED: if (press) next_state = RESET1;
        RESET1:  if (!press) next_state = RESET2;
        RESET2:  if (bell || return_cnt == RETURN_CYCLES - 32'd1) next_state = SEARCH;
        ABORT: begin
          if (bell)       next_state = SEARCH;
          else if (press) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Counters only run while the state is held, so any entry starts them from zero.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      motor_state   <= MOTOR_STOP;
      overwrite     <= 1'b0;
      search_cnt    <= '0;
      return_cnt    <= '0;
      color_latched <= '0;
    end else begin
      state       <= next_state;
      motor_state <= motor_of(next_state);
      overwrite   <= overwrite_of(next_state);
      search_cnt  <= (state == SEARCH && next_state == SEARCH) ? search_cnt + 32'd1 : '0;
      return_cnt  <= (state == RESET2 && next_state == RESET2) ? return_cnt + 32'd1 : '0;
      if (state == SEARCH && next_state != SEARCH)
        color_latched <= color_mode;
    end
  end

endmodule

// File: tb/tb_robot_fsm.sv
// tb/tb_robot_fsm.sv - directed and randomized checks of robot_fsm against a named-state reference model
module tb_robot_fsm;

  localparam int          TIMEOUT   = 10;
  localparam int          RETURNS   = 8;
  localparam logic [31:0] ABORT_HEX = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic [1:0]  key;
  logic        bell;
  logic [31:0] hex_data;
  logic [7:0]  distance;
  logic        proximity;
  logic [2:0]  pixel_location;
  logic [1:0]  color_mode;
  logic        overwrite;
  logic [4:0]  motor_state;

  int total = 0;
  int bad   = 0;

  string      ms;
  int         waited;
  int         returned;
  logic [1:0] m_color;
  logic       hist[$];

  robot_fsm #(
    .STOP_DIST      (8'd20),
    .SEARCH_TIMEOUT (32'd10),
    .RETURN_CYCLES  (32'd8),
    .ABORT_WORD     (ABORT_HEX)
  ) dut (
    .CLOCK_50       (clk),
    .KEY            (key),
    .bell           (bell),
    .hex_data       (hex_data),
    .distance       (distance),
    .proximity      (proximity),
    .pixel_location (pixel_location),
    .color_mode     (color_mode),
    .overwrite      (overwrite),
    .motor_state    (motor_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] m_motor(input string s);
    if (s == "SEARCH")  return 5'b01000;
    if (s == "FORWARD") return 5'b00001;
    if (s == "TURN_L")  return 5'b00010;
    if (s == "TURN_R")  return 5'b00100;
    if (s == "RESET2")  return 5'b10000;
    return 5'b00000;
  endfunction

  function automatic logic m_ov(input string s);
    return (s == "ARRIVED" || s == "RESET1" || s == "RESET2" || s == "ABORT");
  endfunction

  function automatic string dir_of(input logic [2:0] p);
    if (p == 3'b010) return "FORWARD";
    if (p == 3'b100) return "TURN_L";
    if (p == 3'b001) return "TURN_R";
    return "";
  endfunction

  function automatic bit moving(input string s);
    return (s == "FORWARD" || s == "TURN_L" || s == "TURN_R");
  endfunction

  task automatic model_reset();
    ms       = "IDLE";
    waited   = 0;
    returned = 0;
    m_color  = 2'b00;
    hist.delete();
    hist.push_back(1'b1);
    hist.push_back(1'b1);
  endtask

  // The button is seen two edges after it is driven.
  task automatic model_step();
    logic  vis;
    bit    near;
    string d;
    string nxt;
    vis  = hist.pop_front();
    hist.push_back(key[1]);
    near = proximity || (int'(distance) <= 20);
    d    = dir_of(pixel_location);
    nxt  = ms;
    if (ms != "IDLE" && hex_data == ABORT_HEX) nxt = "ABORT";
    else if (ms == "IDLE") begin
      if (bell) nxt = "SEARCH";
    end else if (ms == "SEARCH") begin
      if (d != "") nxt = d;
      else begin
        waited++;
        if (waited == TIMEOUT) nxt = "ABORT";
      end
    end else if (moving(ms)) begin
      if (near) nxt = "HALT";
      else if (color_mode != m_color) nxt = "SEARCH";
      else nxt = (d == "") ? "SEARCH" : d;
    end else if (ms == "HALT") begin
      if (!near) nxt = (d == "FORWARD") ? "ARRIVED" : "SEARCH";
    end else if (ms == "ARRIVED") begin
      if (!vis) nxt = "RESET1";
    end else if (ms == "RESET1") begin
      if (vis) nxt = "RESET2";
    end else if (ms == "RESET2") begin
      returned++;
      if (bell || returned == RETURNS) nxt = "SEARCH";
    end else if (ms == "ABORT") begin
      if (bell) nxt = "SEARCH";
      else if (!vis) nxt = "IDLE";
    end
    if (nxt == "SEARCH" && ms != "SEARCH") waited = 0;
    if (nxt == "RESET2" && ms != "RESET2") returned = 0;
    if (ms == "SEARCH" && moving(nxt)) m_color = color_mode;
    ms = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check({"model_motor_", ms}, 32'(motor_state), 32'(m_motor(ms)));
    check({"model_ov_", ms}, 32'(overwrite), 32'(m_ov(ms)));
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic expect_out(input string tag, input logic [4:0] m, input logic o);
    check({tag, "_motor"}, 32'(motor_state), 32'(m));
    check({tag, "_ov"}, 32'(overwrite), 32'(o));
  endtask

  task automatic do_reset();
    key[0] = 1'b0;
    #1;
    expect_out("async_reset", 5'b00000, 1'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    key[0] = 1'b1;
  endtask

  initial begin
    key = 2'b11; bell = 1'b0; hex_data = '0; distance = 8'd200;
    proximity = 1'b0; pixel_location = 3'b000; color_mode = 2'b00;
    #2;
    do_reset();
    tick_n(3);                      expect_out("idle_hold", 5'b00000, 1'b0);
    bell = 1'b1; tick(); bell = 1'b0; expect_out("bell_search", 5'b01000, 1'b0);
    pixel_location = 3'b010; tick(); expect_out("steer_fwd", 5'b00001, 1'b0);
    pixel_location = 3'b001; tick(); expect_out("steer_right", 5'b00100, 1'b0);
    pixel_location = 3'b100; tick(); expect_out("steer_left", 5'b00010, 1'b0);
    pixel_location = 3'b000; tick(); expect_out("lost_search", 5'b01000, 1'b0);
    pixel_location = 3'b010; tick(); expect_out("reacquire", 5'b00001, 1'b0);
    proximity = 1'b1; tick();         expect_out("prox_halt", 5'b00000, 1'b0);
    tick();                           expect_out("halt_hold", 5'b00000, 1'b0);
    proximity = 1'b0; tick();         expect_out("arrived", 5'b00000, 1'b1);
    pixel_location = 3'b000;
    key[1] = 1'b0; tick_n(3);         expect_out("arrived_press", 5'b00000, 1'b1);
    key[1] = 1'b1; tick_n(2);         expect_out("reset1_hold", 5'b00000, 1'b1);
    tick();                           expect_out("reset2_enter", 5'b10000, 1'b1);
    tick_n(RETURNS - 1);              expect_out("reset2_last", 5'b10000, 1'b1);
    tick();                           expect_out("return_search", 5'b01000, 1'b0);
    pixel_location = 3'b010; tick();  expect_out("fwd_again", 5'b00001, 1'b0);
    distance = 8'd21; tick();         expect_out("dist_21_moves", 5'b00001, 1'b0);
    distance = 8'd20; tick();         expect_out("dist_20_stops", 5'b00000, 1'b0);
    distance = 8'd200; pixel_location = 3'b000; tick(); expect_out("halt_to_search", 5'b01000, 1'b0);
    tick_n(TIMEOUT - 1);              expect_out("timeout_edge", 5'b01000, 1'b0);
    tick();                           expect_out("timeout_abort", 5'b00000, 1'b1);
    bell = 1'b1; tick(); bell = 1'b0; expect_out("abort_bell", 5'b01000, 1'b0);
    pixel_location = 3'b010; tick();  expect_out("fwd_pre_abort", 5'b00001, 1'b0);
    hex_data = ABORT_HEX; tick();     expect_out("abort_word", 5'b00000, 1'b1);
    hex_data = 32'h0; pixel_location = 3'b000;
    key[1] = 1'b0; tick_n(2);         expect_out("abort_wait_sync", 5'b00000, 1'b1);
    tick();                           expect_out("abort_to_idle", 5'b00000, 1'b0);
    key[1] = 1'b1; tick_n(2);
    bell = 1'b1; tick(); bell = 1'b0;
    pixel_location = 3'b010; tick();  expect_out("color_latch_fwd", 5'b00001, 1'b0);
    color_mode = 2'b01; tick();       expect_out("color_change", 5'b01000, 1'b0);
    tick();                           expect_out("color_relatch", 5'b00001, 1'b0);
    tick();                           expect_out("color_steady", 5'b00001, 1'b0);
    do_reset();
    tick();                           expect_out("post_reset_idle", 5'b00000, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      bell           = ($urandom_range(15, 0) == 0);
      hex_data       = ($urandom_range(59, 0) == 0) ? ABORT_HEX : $urandom;
      proximity      = ($urandom_range(9, 0) == 0);
      distance       = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(40, 0)) : 8'($urandom_range(255, 41));
      pixel_location = ($urandom_range(1, 0) == 0) ? 3'b000 : 3'($urandom_range(7, 0));
      if ($urandom_range(19, 0) == 0) color_mode = 2'($urandom_range(3, 0));
      if ($urandom_range(9, 0) == 0) key[1] = ~key[1];
      if ($urandom_range(499, 0) == 0) do_reset();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
